// File: rtl/slave_tx_sched_if.sv
// slave_tx_sched_if: requester and slave_comm TX signals of slave_tx_sched.
// master is the scheduler side, slave is the environment side.
interface slave_tx_sched_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    req_i;
    logic [16*NREQ-1:0] byte_num_i;
    logic [8*NREQ-1:0]  byte_i;
    logic [NREQ-1:0]    gnt_o;
    logic [NREQ-1:0]    rd_o;
    logic               slave_tx_byte_num_en_o;
    logic [15:0]        slave_tx_byte_num_o;
    logic               slave_tx_byte_en_o;
    logic [7:0]         slave_tx_byte_o;
    logic               slave_tx_ack_i;
    logic               busy_o;
    logic [1:0]         cur_ch_o;
    logic               err_zero_len_o;
    logic               timeout_o;

    modport master (
        input  req_i, byte_num_i, byte_i, slave_tx_ack_i,
        output gnt_o, rd_o,
        output slave_tx_byte_num_en_o, slave_tx_byte_num_o,
        output slave_tx_byte_en_o, slave_tx_byte_o,
        output busy_o, cur_ch_o, err_zero_len_o, timeout_o
    );

    modport slave (
        output req_i, byte_num_i, byte_i, slave_tx_ack_i,
        input  gnt_o, rd_o,
        input  slave_tx_byte_num_en_o, slave_tx_byte_num_o,
        input  slave_tx_byte_en_o, slave_tx_byte_o,
        input  busy_o, cur_ch_o, err_zero_len_o, timeout_o
    );
endinterface

// File: rtl/slave_tx_sched.sv
// slave_tx_sched: round-robin scheduler sharing the slave_comm TX path.
// Define SLAVE_TX_TIMEOUT_EN to give up on a missing ack after ACK_TIMEOUT.
module slave_tx_sched #(
    parameter int          NREQ        = 3,
    parameter logic [15:0] ACK_TIMEOUT = 16'd50000,
    parameter logic [7:0]  GAP_CYC     = 8'd4
) (
    input logic              clk_i,
    input logic              rst_n_i,
    slave_tx_sched_if.master bus
);
    typedef enum logic [2:0] {IDLE, NUM, DATA, WAIT_ACK, GAP} state_t;

    state_t          state;
    logic [1:0]      last_served;
    logic [1:0]      cur_ch;
    logic [15:0]     len;
    logic [15:0]     rd_cnt;
    logic [15:0]     tx_cnt;
    logic [7:0]      gap_cnt;
    logic            rd_d1;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] rd_q;
    logic            num_en_q;
    logic [15:0]     num_q;
    logic            byte_en_q;
    logic [7:0]      byte_q;
    logic            busy_q;
    logic            err_q;

    logic            found;
    logic [1:0]      win_idx;
    logic [15:0]     win_len;
    logic [7:0]      sel_byte;

`ifdef SLAVE_TX_TIMEOUT_EN
    logic [15:0]     to_cnt;
    logic            timeout_q;
`endif

    function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
        onehot = '0;
        for (int k = 0; k < NREQ; k++)
            if (idx == 2'(k)) onehot[k] = 1'b1;
    endfunction

    // Round-robin search beginning just after the last served requester
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        win_len = '0;
        for (int i = 1; i <= NREQ; i++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!found && bus.req_i[k] &&
                    k == (int'(last_served) + i) % NREQ) begin
                    found   = 1'b1;
                    win_idx = 2'(k);
                    win_len = bus.byte_num_i[16*k +: 16];
                end
            end
        end
    end

    // Byte lane of the requester currently being served
    always_comb begin
        sel_byte = '0;
        for (int k = 0; k < NREQ; k++)
            if (cur_ch == 2'(k)) sel_byte = bus.byte_i[8*k +: 8];
    end

    // Scheduler FSM with registered outputs and single-cycle strobes
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            last_served <= 2'(NREQ - 1);
            cur_ch      <= '0;
            len         <= '0;
            rd_cnt      <= '0;
            tx_cnt      <= '0;
            gap_cnt     <= '0;
            rd_d1       <= 1'b0;
            gnt_q       <= '0;
            rd_q        <= '0;
            num_en_q    <= 1'b0;
            num_q       <= '0;
            byte_en_q   <= 1'b0;
            byte_q      <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef SLAVE_TX_TIMEOUT_EN
            to_cnt      <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            gnt_q     <= '0;
            rd_q      <= '0;
            num_en_q  <= 1'b0;
            byte_en_q <= 1'b0;
            err_q     <= 1'b0;
            rd_d1     <= |rd_q;
`ifdef SLAVE_TX_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (found) begin
                        gnt_q   <= onehot(win_idx);
                        cur_ch  <= win_idx;
                        len     <= win_len;
                        rd_cnt  <= '0;
                        tx_cnt  <= '0;
                        busy_q  <= 1'b1;
                        if (win_len == 16'd0) begin
                            err_q       <= 1'b1;
                            last_served <= win_idx;
                            gap_cnt     <= '0;
                            state       <= GAP;
                        end else begin
                            state <= NUM;
                        end
                    end
                end
                NUM: begin
                    num_en_q <= 1'b1;
                    num_q    <= len;
                    state    <= DATA;
                end
                DATA: begin
                    if (rd_cnt != len) begin
                        rd_q   <= onehot(cur_ch);
                        rd_cnt <= rd_cnt + 16'd1;
                    end
                    if (rd_d1) begin
                        byte_q    <= sel_byte;
                        byte_en_q <= 1'b1;
                        tx_cnt    <= tx_cnt + 16'd1;
                        if (tx_cnt == len - 16'd1) begin
                            state <= WAIT_ACK;
`ifdef SLAVE_TX_TIMEOUT_EN
                            to_cnt <= '0;
`endif
                        end
                    end
                end
                WAIT_ACK: begin
                    if (bus.slave_tx_ack_i) begin
                        last_served <= cur_ch;
                        gap_cnt     <= '0;
                        state       <= GAP;
                    end
`ifdef SLAVE_TX_TIMEOUT_EN
                    else if (to_cnt == ACK_TIMEOUT - 16'd1) begin
                        timeout_q   <= 1'b1;
                        last_served <= cur_ch;
                        gap_cnt     <= '0;
                        state       <= GAP;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
`endif
                end
                GAP: begin
                    if ({1'b0, gap_cnt} + 9'd1 >= {1'b0, GAP_CYC}) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt_o                  = gnt_q;
    assign bus.rd_o                   = rd_q;
    assign bus.slave_tx_byte_num_en_o = num_en_q;
    assign bus.slave_tx_byte_num_o    = num_q;
    assign bus.slave_tx_byte_en_o     = byte_en_q;
    assign bus.slave_tx_byte_o        = byte_q;
    assign bus.busy_o                 = busy_q;
    assign bus.cur_ch_o               = cur_ch;
    assign bus.err_zero_len_o         = err_q;

`ifdef SLAVE_TX_TIMEOUT_EN
    assign bus.timeout_o = timeout_q;
`else
    logic unused_ack_timeout;
    assign unused_ack_timeout = ^ACK_TIMEOUT;
    assign bus.timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_slave_tx_sched.sv
// tb_slave_tx_sched: directed vectors plus corner sequences for slave_tx_sched.
// Build with SLAVE_TX_TIMEOUT_EN to also exercise the ack timeout.
module tb_slave_tx_sched;
    localparam int GAP = 4;
`ifdef SLAVE_TX_TIMEOUT_EN
    localparam logic [15:0] ACK_TO = 16'd100;
`else
    localparam logic [15:0] ACK_TO = 16'd50000;
`endif

    typedef struct {
        int ch;
        int len;
        int base;
        int ack_dly;
        int exp_ch;
        int exp_err;
        int exp_busy;
    } vec_t;

    logic clk_i;
    logic rst_n_i;
    slave_tx_sched_if #(.NREQ(3)) bus();

    slave_tx_sched #(
        .NREQ(3),
        .ACK_TIMEOUT(ACK_TO),
        .GAP_CYC(8'(GAP))
    ) dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .bus(bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_num, n_rd, n_err, n_to, to_total, lat_bad;
    logic [15:0] num_val;
    int gnt_q[$];
    logic [7:0] byte_q[$];
    int rdcyc_q[$];
    logic [7:0] base[3];
    logic [7:0] dcnt[3];
    logic [2:0] rs, gs;

    always @(posedge clk_i) cyc++;

    // requester model: byte valid in the cycle after each rd pulse
    always @(posedge clk_i) begin
        rs = bus.rd_o;
        gs = bus.gnt_o;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (gs[k]) dcnt[k] = 8'd0;
            if (rs[k]) begin
                bus.byte_i[8*k +: 8] = base[k] + dcnt[k];
                dcnt[k] = dcnt[k] + 8'd1;
            end
        end
    end

    // output monitor
    always @(negedge clk_i) begin
        for (int k = 0; k < 3; k++)
            if (bus.gnt_o[k]) gnt_q.push_back(k);
        if (bus.slave_tx_byte_num_en_o) begin
            n_num++;
            num_val = bus.slave_tx_byte_num_o;
        end
        if (|bus.rd_o) begin
            n_rd++;
            rdcyc_q.push_back(cyc);
        end
        if (bus.slave_tx_byte_en_o) begin
            byte_q.push_back(bus.slave_tx_byte_o);
            if (rdcyc_q.size() == 0) lat_bad++;
            else if (cyc - rdcyc_q.pop_front() != 2) lat_bad++;
        end
        if (bus.err_zero_len_o) n_err++;
        if (bus.timeout_o) begin
            n_to++;
            to_total++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input longint got,
                         input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic clr();
        n_num = 0; n_rd = 0; n_err = 0; n_to = 0; lat_bad = 0;
        num_val = '0;
        gnt_q.delete();
        byte_q.delete();
        rdcyc_q.delete();
    endtask

    function automatic longint all_outs();
        return longint'({bus.gnt_o, bus.rd_o,
                         bus.slave_tx_byte_num_en_o, bus.slave_tx_byte_num_o,
                         bus.slave_tx_byte_en_o, bus.slave_tx_byte_o,
                         bus.busy_o, bus.cur_ch_o,
                         bus.err_zero_len_o, bus.timeout_o});
    endfunction

    task automatic wait_bytes(input int n);
        int k = 0;
        while (byte_q.size() < n && k < 8 * n + 40) begin
            step();
            k++;
        end
    endtask

    task automatic ack_and_gap(input string name, input int exp);
        int k;
        bus.slave_tx_ack_i = 1'b1;
        step();
        bus.slave_tx_ack_i = 1'b0;
        k = 1;
        while (bus.busy_o && k < 50) begin
            step();
            k++;
        end
        check(name, k, exp);
    endtask

    task automatic run_pkt(input vec_t v);
        int k;
        int bad;
        clr();
        bus.byte_num_i[16*v.ch +: 16] = 16'(v.len);
        base[v.ch] = 8'(v.base);
        bus.req_i[v.ch] = 1'b1;
        k = 0;
        while (gnt_q.size() == 0 && k < 20) begin
            step();
            k++;
        end
        bus.req_i[v.ch] = 1'b0;
        check("gnt_count", gnt_q.size(), 1);
        if (gnt_q.size() > 0) check("gnt_ch", gnt_q[0], v.exp_ch);
        check("cur_ch", bus.cur_ch_o, v.exp_ch);
        check("err_zero_len", n_err, v.exp_err);
        if (v.len == 0) begin
            k = 0;
            while (bus.busy_o && k < 50) begin
                step();
                k++;
            end
            check("zero_gap", k, v.exp_busy);
            check("zero_strobes", n_num + n_rd + byte_q.size(), 0);
        end else begin
            wait_bytes(v.len);
            check("num_en_count", n_num, 1);
            check("num_val", num_val, v.len);
            check("rd_count", n_rd, v.len);
            check("byte_count", byte_q.size(), v.len);
            bad = 0;
            for (int i = 0; i < byte_q.size(); i++)
                if (byte_q[i] != 8'(v.base + i)) bad++;
            check("byte_data", bad, 0);
            check("rd_to_byte_lat", lat_bad, 0);
            repeat (v.ack_dly) step();
            check("await_ack", bus.busy_o, 1);
            ack_and_gap("ack_gap", v.exp_busy);
        end
    endtask

    initial begin
        vec_t vt[5];
        int   k;
        int   bad;
        int   exp_ord[4];
        vt[0] = '{0, 3, 8'h01, 10, 0, 0, GAP + 1};
        vt[1] = '{1, 0, 8'h00, 0, 1, 1, GAP};
        vt[2] = '{2, 1, 8'hA0, 0, 2, 0, GAP + 1};
        vt[3] = '{1, 4, 8'h10, 3, 1, 0, GAP + 1};
        vt[4] = '{0, 2, 8'hFE, 1, 0, 0, GAP + 1};
        exp_ord = '{0, 1, 2, 0};

        rst_n_i = 1'b0;
        bus.req_i = '0;
        bus.byte_num_i = '0;
        bus.slave_tx_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            base[i] = 8'h00;
            dcnt[i] = 8'h00;
        end
        to_total = 0;
        clr();

        // reset state
        step();
        step();
        check("reset_outputs", all_outs(), 0);
        check("reset_busy", bus.busy_o, 0);
        rst_n_i = 1'b1;
        step();
        check("idle_outputs", all_outs(), 0);

        // directed single-requester packets
        for (int i = 0; i < 5; i++) run_pkt(vt[i]);

        // ack while idle is ignored; next packet still waits for its ack
        bus.slave_tx_ack_i = 1'b1;
        step();
        bus.slave_tx_ack_i = 1'b0;
        step();
        check("idle_ack_busy", bus.busy_o, 0);
        run_pkt('{2, 2, 8'h30, 6, 2, 0, GAP + 1});

        // reset in DATA after the 2nd of 5 bytes
        clr();
        bus.byte_num_i[16 +: 16] = 16'd5;
        base[1] = 8'h70;
        bus.req_i[1] = 1'b1;
        k = 0;
        while (gnt_q.size() == 0 && k < 20) begin
            step();
            k++;
        end
        bus.req_i[1] = 1'b0;
        wait_bytes(2);
        check("rst_pre_bytes", byte_q.size(), 2);
        rst_n_i = 1'b0;
        #1;
        check("rst_async_outs", all_outs(), 0);
        step();
        check("rst_hold_outs1", all_outs(), 0);
        step();
        check("rst_hold_outs2", all_outs(), 0);
        clr();
        rst_n_i = 1'b1;
        repeat (12) step();
        check("rst_no_rd", n_rd, 0);
        check("rst_no_bytes", byte_q.size() + n_num, 0);
        check("rst_idle", bus.busy_o, 0);

        // all three held: round-robin from requester 0
        clr();
        for (int i = 0; i < 3; i++) begin
            bus.byte_num_i[16*i +: 16] = 16'd6;
            base[i] = 8'(8'h40 + 8'h10 * i);
        end
        bus.req_i = 3'b111;
        for (int p = 0; p < 4; p++) begin
            k = 0;
            while (byte_q.size() < 6 * (p + 1) && k < 100) begin
                step();
                k++;
                if (gnt_q.size() >= 4) bus.req_i = '0;
            end
            check("rr_pkt_done", byte_q.size(), 6 * (p + 1));
            bus.slave_tx_ack_i = 1'b1;
            step();
            if (gnt_q.size() >= 4) bus.req_i = '0;
            bus.slave_tx_ack_i = 1'b0;
        end
        k = 0;
        while (bus.busy_o && k < 50) begin
            step();
            k++;
        end
        check("rr_gnt_count", gnt_q.size(), 4);
        for (int p = 0; p < 4; p++)
            if (gnt_q.size() > p) check("rr_order", gnt_q[p], exp_ord[p]);
        check("rr_num_en", n_num, 4);
        bad = 0;
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 6; i++)
                if (byte_q.size() > 6 * p + i &&
                    byte_q[6*p+i] != 8'(base[exp_ord[p]] + i)) bad++;
        check("rr_bytes", bad, 0);
        check("rr_lat", lat_bad, 0);

`ifdef SLAVE_TX_TIMEOUT_EN
        // no ack: timeout then the next requester is served
        clr();
        bus.byte_num_i[16 +: 16] = 16'd1;
        bus.byte_num_i[32 +: 16] = 16'd1;
        bus.req_i = 3'b110;
        wait_bytes(1);
        check("to_first_ch", gnt_q.size() > 0 ? gnt_q[0] : -1, 1);
        bus.req_i[1] = 1'b0;
        k = 0;
        while (n_to == 0 && k < 200) begin
            step();
            k++;
        end
        check("to_latency", k, 100);
        k = 0;
        while (gnt_q.size() < 2 && k < 40) begin
            step();
            k++;
        end
        bus.req_i = '0;
        check("to_next_ch", gnt_q.size() > 1 ? gnt_q[1] : -1, 2);
        wait_bytes(2);
        ack_and_gap("to_ack_gap", GAP + 1);
        check("to_pulses", n_to, 1);
`else
        check("timeout_tied", to_total, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
